// File: rtl/ciram_mirror_if.sv
// PPU-side bus for the nametable VRAM: address, one-cycle read/write
// strobes, write data, and the registered read data with its valid strobe.
interface ciram_mirror_if #(
  parameter int unsigned DATA_W = 8
);
  logic [13:0]       ppu_addr;
  logic              ppu_rd;
  logic              ppu_we;
  logic [DATA_W-1:0] ppu_wdata;
  logic [DATA_W-1:0] ppu_rdata;
  logic              rd_valid;

  modport master (
    output ppu_addr, ppu_rd, ppu_we, ppu_wdata,
    input  ppu_rdata, rd_valid
  );

  modport slave (
    input  ppu_addr, ppu_rd, ppu_we, ppu_wdata,
    output ppu_rdata, rd_valid
  );
endinterface

// File: rtl/ciram_mirror.sv
// Parametrised nametable VRAM. PPU addresses $2000-$3EFF are folded onto
// the physical array by the selected mirroring mode. Reads are registered
// with a one-cycle valid strobe. A clear engine fills the whole array with
// CLEAR_VAL after reset and on request; PPU traffic is ignored meanwhile.
module ciram_mirror #(
  parameter int unsigned       ADDR_W    = 11,
  parameter int unsigned       DATA_W    = 8,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] mirror_mode,
  input  logic       clear_req,
  output logic       busy,
  ciram_mirror_if.slave bus
);

  localparam bit FOUR_OK = (ADDR_W >= 12);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rd_valid_q, rd_valid_d;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  logic              in_range;
  logic [1:0]        nt;
  logic [9:0]        off;
  logic [1:0]        bank;
  logic [11:0]       phys_full;
  logic [ADDR_W-1:0] phys;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Address decode and mirroring: fold the four logical nametables onto banks
  always_comb begin
    in_range = (bus.ppu_addr >= 14'h2000) && (bus.ppu_addr <= 14'h3EFF);
    nt       = bus.ppu_addr[11:10];
    off      = bus.ppu_addr[9:0];
    case (mirror_mode)
      3'd0:    bank = {1'b0, nt[1]};
      3'd2:    bank = 2'b00;
      3'd3:    bank = 2'b01;
      3'd4:    bank = FOUR_OK ? nt : {1'b0, nt[0]};
      default: bank = {1'b0, nt[0]};
    endcase
    // bank[1] is only ever set for four-screen, so the truncation for
    // ADDR_W=11 never drops a live bit.
    phys_full = {bank, off};
    phys      = ADDR_W'(phys_full);
  end

  // Next-state, clear counter, array write port and read-data selection
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    rd_valid_d = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = phys;
    mem_wdata  = bus.ppu_wdata;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (in_range) begin
          mem_we = bus.ppu_we;
          if (bus.ppu_rd) begin
            rd_valid_d = 1'b1;
            rdata_d    = bus.ppu_we ? bus.ppu_wdata : mem_q[phys];
          end
        end
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = CLEAR_VAL;
        cnt_d     = cnt_q + ADDR_W'(1);
        // Leave on the last word so the counter wrap never restarts a clear.
        if (cnt_q == '1) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Control and read-data registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Array write port; contents are not reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign busy          = (state_q == ST_CLEAR);
  assign bus.ppu_rdata = rdata_q;
  assign bus.rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_ciram_mirror.sv
// Directed bench for ciram_mirror: a 2 KiB instance and a 4 KiB
// four-screen instance share stimulus; expected values are hand-computed.
module tb_ciram_mirror;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic        clr = 1'b0;
  logic [13:0] a = 14'h0;
  logic        rd = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  wd = 8'h0;
  logic        busy11, busy12;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  ciram_mirror_if #(.DATA_W(8)) bus11 ();
  ciram_mirror_if #(.DATA_W(8)) bus12 ();

  assign bus11.ppu_addr  = a;
  assign bus11.ppu_rd    = rd;
  assign bus11.ppu_we    = we;
  assign bus11.ppu_wdata = wd;
  assign bus12.ppu_addr  = a;
  assign bus12.ppu_rd    = rd;
  assign bus12.ppu_we    = we;
  assign bus12.ppu_wdata = wd;

  ciram_mirror #(.ADDR_W(11), .DATA_W(8), .CLEAR_VAL(8'h00)) dut11 (
    .clk         (clk),
    .reset_n     (reset_n),
    .mirror_mode (mode),
    .clear_req   (clr),
    .busy        (busy11),
    .bus         (bus11)
  );

  ciram_mirror #(.ADDR_W(12), .DATA_W(8), .CLEAR_VAL(8'h00)) dut12 (
    .clk         (clk),
    .reset_n     (reset_n),
    .mirror_mode (mode),
    .clear_req   (clr),
    .busy        (busy12),
    .bus         (bus12)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wr(input logic [13:0] addr, input logic [7:0] data);
    a  = addr;
    wd = data;
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic do_rd(input logic [13:0] addr);
    a  = addr;
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  // Read on the 2 KiB instance, expect a valid strobe and the given data
  task automatic rd11(input string tag, input logic [13:0] addr, input logic [7:0] exp);
    do_rd(addr);
    check_eq({tag, "_v"}, 32'(bus11.rd_valid), 32'd1);
    check_eq(tag, 32'(bus11.ppu_rdata), 32'(exp));
  endtask

  task automatic rd12(input string tag, input logic [13:0] addr, input logic [7:0] exp);
    do_rd(addr);
    check_eq({tag, "_v"}, 32'(bus12.rd_valid), 32'd1);
    check_eq(tag, 32'(bus12.ppu_rdata), 32'(exp));
  endtask

  task automatic count_busy11(input int unsigned start, output int unsigned n);
    n = start;
    for (int unsigned i = 0; i < 10000; i++) begin
      if (!busy11) break;
      tick();
      n++;
    end
  endtask

  initial begin
    int unsigned n;

    // Reset state
    #23;
    check_eq("rst_busy11", 32'(busy11), 32'd1);
    check_eq("rst_busy12", 32'(busy12), 32'd1);
    check_eq("rst_rdata", 32'(bus11.ppu_rdata), 32'h0);
    check_eq("rst_valid", 32'(bus11.rd_valid), 32'd0);
    reset_n = 1'b1;

    // Power-up clear length
    count_busy11(0, n);
    check_eq("init_clear_len", n, 32'd2048);

    // Cleared contents, valid lasts one cycle
    mode = 3'd0;
    rd11("rd_2000", 14'h2000, 8'h00);
    rd11("rd_27FF", 14'h27FF, 8'h00);
    rd11("rd_2ABC", 14'h2ABC, 8'h00);
    tick();
    check_eq("valid_drop", 32'(bus11.rd_valid), 32'd0);

    // Vertical then horizontal mirroring
    mode = 3'd1;
    do_wr(14'h2005, 8'h5A);
    rd11("vert_2805", 14'h2805, 8'h5A);
    rd11("vert_2405", 14'h2405, 8'h00);
    mode = 3'd0;
    do_wr(14'h2010, 8'hC3);
    rd11("horz_2410", 14'h2410, 8'hC3);

    // Single-screen B and A, $3xxx alias
    mode = 3'd3;
    do_wr(14'h2C01, 8'h77);
    rd11("sb_2001", 14'h2001, 8'h77);
    rd11("sb_2401", 14'h2401, 8'h77);
    rd11("sb_2801", 14'h2801, 8'h77);
    mode = 3'd2;
    rd11("sa_2001", 14'h2001, 8'h00);
    mode = 3'd3;
    rd11("sb_3C01", 14'h3C01, 8'h77);

    // Write-first on same-cycle read+write
    mode = 3'd1;
    a = 14'h2100; wd = 8'h99; we = 1'b1; rd = 1'b1;
    tick();
    we = 1'b0; rd = 1'b0;
    check_eq("wf_valid", 32'(bus11.rd_valid), 32'd1);
    check_eq("wf_data", 32'(bus11.ppu_rdata), 32'h99);
    rd11("wf_reread", 14'h2100, 8'h99);

    // Range boundaries: out-of-range leaves data and valid alone
    do_rd(14'h1FFF);
    check_eq("oor_1FFF_v", 32'(bus11.rd_valid), 32'd0);
    check_eq("oor_1FFF_d", 32'(bus11.ppu_rdata), 32'h99);
    do_rd(14'h3F00);
    check_eq("oor_3F00_v", 32'(bus11.rd_valid), 32'd0);
    check_eq("oor_3F00_d", 32'(bus11.ppu_rdata), 32'h99);
    do_wr(14'h3F00, 8'h11);
    rd11("oor_wr_2700", 14'h2700, 8'h00);
    do_wr(14'h3EFF, 8'hAB);
    rd11("top_2EFF", 14'h2EFF, 8'hAB);

    // Requested clear; accesses during it are dropped
    do_wr(14'h2300, 8'h42);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_eq("clr_busy", 32'(busy11), 32'd1);
    do_wr(14'h2000, 8'hEE);
    do_rd(14'h2300);
    check_eq("clr_rd_v", 32'(bus11.rd_valid), 32'd0);
    count_busy11(2, n);
    check_eq("clr_len", n, 32'd2048);
    rd11("clr_2005", 14'h2005, 8'h00);
    rd11("clr_2010", 14'h2010, 8'h00);
    rd11("clr_2C01", 14'h2C01, 8'h00);
    rd11("clr_2100", 14'h2100, 8'h00);
    rd11("clr_2300", 14'h2300, 8'h00);
    rd11("clr_2EFF", 14'h2EFF, 8'h00);
    rd11("clr_2000", 14'h2000, 8'h00);

    // Reset in the middle of a clear restarts it from word 0
    do_wr(14'h2001, 8'h5C);
    rd11("pre_rst_2001", 14'h2001, 8'h5C);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 1000; i++) tick();
    check_eq("mid_busy", 32'(busy11), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 32'(busy11), 32'd1);
    check_eq("mid_rst_rdata", 32'(bus11.ppu_rdata), 32'h0);
    tick(); tick(); tick();
    reset_n = 1'b1;
    count_busy11(0, n);
    check_eq("restart_len", n, 32'd2048);

    // Four-screen on the 4 KiB instance; mode 4 acts as vertical at 2 KiB
    for (int unsigned i = 0; i < 10000; i++) begin
      if (!busy12) break;
      tick();
    end
    check_eq("busy12_done", 32'(busy12), 32'd0);
    mode = 3'd4;
    do_wr(14'h2000, 8'h11);
    do_wr(14'h2400, 8'h22);
    do_wr(14'h2800, 8'h33);
    do_wr(14'h2C00, 8'h44);
    rd12("fs12_2000", 14'h2000, 8'h11);
    rd12("fs12_2400", 14'h2400, 8'h22);
    rd12("fs12_2800", 14'h2800, 8'h33);
    rd12("fs12_2C00", 14'h2C00, 8'h44);
    rd11("fs11_2000", 14'h2000, 8'h33);
    rd11("fs11_2400", 14'h2400, 8'h44);
    rd11("fs11_2800", 14'h2800, 8'h33);
    rd11("fs11_2C00", 14'h2C00, 8'h44);
    mode = 3'd0;
    rd12("h12_2400", 14'h2400, 8'h11);
    mode = 3'd3;
    rd12("sb12_2000", 14'h2000, 8'h22);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ciram_mirror.md
Name: ciram_mirror

Overview:
Parametrised nametable VRAM for the PPU. It replaces the fixed 2 KiB CIRAM with a configurable depth and width. It decodes PPU addresses $2000-$3EFF through a selectable mirroring mode (horizontal, vertical, single-screen A/B, four-screen) and gives a registered read with a valid strobe. A built-in clear engine zeroes the array after reset or on request. It sits between the PPU bus and the cartridge mirroring control.

Parameters:
ADDR_W, 11, physical word-address width; depth = 2**ADDR_W (11 = 2 KiB, 12 = 4 KiB four-screen)
DATA_W, 8, data word width
CLEAR_VAL, 0, value written to every word by the clear engine (DATA_W bits)

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
mirror_mode  in  3  0=horizontal, 1=vertical, 2=single A, 3=single B, 4=four-screen; 5-7 treated as vertical
ppu_addr  in  14  PPU address
ppu_rd  in  1  read request, one cycle
ppu_we  in  1  write enable, one cycle
ppu_wdata  in  DATA_W  write data
clear_req  in  1  pulse: start array clear
ppu_rdata  out  DATA_W  registered read data
rd_valid  out  1  high one cycle when ppu_rdata is updated by a read
busy  out  1  high while the clear engine runs

Behaviour:
- Reset (async, reset_n=0): ppu_rdata=0, rd_valid=0, busy=1, FSM=CLEAR, clear counter=0. The array itself is not reset.
- Address decode: in range iff 0x2000 <= ppu_addr <= 0x3EFF. nt=ppu_addr[11:10], off=ppu_addr[9:0]; $3000-$3EFF alias $2000-$2EFF by construction.
- Bank select: horizontal uses nt[1]; vertical uses nt[0]; single A uses 0; single B uses 1.
- Four-screen uses nt (2 bits), and only when ADDR_W>=12. With ADDR_W=11, mode 4 is treated as vertical.
- Physical address = {bank, off}, zero-extended to ADDR_W. mirror_mode is sampled combinationally on each access cycle; a mode change affects the next access.
- FSM IDLE:
  - ppu_we with an in-range address writes ppu_wdata at the next edge.
  - ppu_rd with an in-range address: ppu_rdata gets the array word at the next edge and rd_valid=1 for exactly that cycle. Read latency is 1 cycle.
  - ppu_rd and ppu_we in the same cycle to the same address: write-first; ppu_rdata returns the new ppu_wdata.
  - Out-of-range access: no write, rd_valid stays 0, ppu_rdata holds.
  - With no read, ppu_rdata holds its last value and rd_valid=0.
  - clear_req=1 moves to CLEAR with counter=0 and busy=1 at the next edge. clear_req has priority over a same-cycle PPU access, which is dropped.
- FSM CLEAR:
  - Each cycle writes CLEAR_VAL at counter, then counter+1.
  - After writing address 2**ADDR_W-1: go to IDLE and set busy=0 on that edge. A clear takes exactly 2**ADDR_W cycles.
  - PPU accesses are ignored (no write, rd_valid=0). clear_req is ignored.
- Reset mid-clear: counter returns to 0 and the clear restarts from the beginning once reset_n rises.
- Counter width is ADDR_W+1 internally, or terminal-compare on all-ones; there must be no wrap back to 0 that restarts the clear.

Test Plan:
- Reset release, ADDR_W=11 -> busy=1 for exactly 2048 cycles then 0; reading $2000, $27FF, $2ABC returns 0 with rd_valid one cycle after each ppu_rd.
- Vertical mode: write 0x5A to $2005, read $2805 -> 0x5A; read $2405 -> 0x00. Switch to horizontal, write 0xC3 to $2010, read $2410 -> 0xC3.
- Single B: write 0x77 to $2C01; read $2001, $2401, $2801 -> all 0x77. Single A read $2001 -> 0x00 (untouched bank 0). Mirror alias: read $3C01 in single B -> 0x77.
- Same-cycle ppu_rd+ppu_we to $2100 with 0x99 -> ppu_rdata=0x99 next cycle. ppu_rd at $1FFF or $3F00 -> rd_valid stays 0, ppu_rdata unchanged.
- clear_req in IDLE after writing data -> busy 2048 cycles; writes issued during busy are lost; afterwards all previously written locations read 0x00.
- Assert reset_n low at clear cycle 1000 for 3 cycles -> busy stays 1 and the clear completes 2048 cycles after reset_n rises. ADDR_W=12, mode 4: write distinct values to $2000/$2400/$2800/$2C00, all four read back distinct.
